rps_match_controller: RTL
=========================

Name: rps_match_controller

Overview:
Initiator side of the stone-paper-scissors game handshake. It drives start and both player moves into the game core, then waits for the core's 8-bit status byte to report the RESULT state. It captures the winner, releases start, and waits for the core to return to IDLE. Across rounds it keeps a best-of match score, and it can supply player 2's move from an internal LFSR (CPU opponent).

Parameters:
WINS_NEEDED, 2, round wins that end a match (1..15)
TIMEOUT, 16, max cycles spent in ISSUE or RELEASE before abort (2..255)
SEED, 8'hA5, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
user_go  in  1  request one round; level sampled in M_IDLE only
user_p1_move  in  2  player 1 move: 00 stone, 01 paper, 10 scissors, 11 invalid
user_p2_move  in  2  player 2 move, used when cpu_mode=0
cpu_mode  in  1  1: player 2 move from LFSR
clear_match  in  1  zero scores/flags; honoured in M_IDLE and M_DONE only
game_status  in  8  core status {state[7:5], winner[4:3], debug[2:0]}; state 000 IDLE, 001 EVALUATE, 010 RESULT; winner 00 tie, 01 p1, 10 p2, 11 invalid
game_start  out  1  start to core (registered)
game_p1_move  out  2  registered move to core
game_p2_move  out  2  registered move to core
score_p1  out  4  player 1 round wins
score_p2  out  4  player 2 round wins
ties  out  8  tie count, saturates at 255
last_winner  out  2  winner code of last completed round
round_done  out  1  one-cycle pulse, valid (non-void) round scored
void_round  out  1  one-cycle pulse, core reported winner 11
match_over  out  1  high in M_DONE
match_winner  out  2  01 p1, 10 p2, 00 none
timeout_err  out  1  sticky handshake-timeout flag
busy  out  1  high in M_ISSUE or M_RELEASE

Behaviour:
- Reset: FSM M_IDLE; lfsr=SEED. All outputs 0, including game_start, moves, scores, ties, last_winner, pulses, match_winner and timeout_err.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Shifts every cycle; not held by any FSM state. cpu_move = lfsr[1:0], with 11 mapped to 00.
- M_IDLE: if clear_match, zero scores/ties/last_winner/timeout_err and stay. Else if user_go:
  - Latch game_p1_move=user_p1_move.
  - Latch game_p2_move = cpu_mode ? cpu_move : user_p2_move.
  - Set game_start=1, zero timeout counter, go M_ISSUE.
  - clear_match has priority over user_go.
- M_ISSUE: game_start=1; moves held stable. When game_status[7:5]==010, capture winner=game_status[4:3] that cycle and go M_RELEASE with game_start=0 on the next cycle. Scoring is registered in the same edge:
  - 01: score_p1+1, round_done=1.
  - 10: score_p2+1, round_done=1.
  - 00: ties+1 (saturating), round_done=1.
  - 11: no count change, void_round=1.
  - last_winner is updated for all four codes.
- M_RELEASE: game_start=0. When game_status[7:5]==000:
  - If score_p1==WINS_NEEDED, set match_winner=01 and go M_DONE.
  - Else if score_p2==WINS_NEEDED, set match_winner=10 and go M_DONE.
  - Else go M_IDLE.
- Timeout: a counter increments each cycle in M_ISSUE/M_RELEASE and resets on each state entry. When it reaches TIMEOUT-1 without the awaited core state: set timeout_err, drive game_start=0, go M_IDLE, count nothing.
- M_DONE: match_over=1; user_go ignored. clear_match zeroes scores, ties, match_winner, last_winner and timeout_err, then goes to M_IDLE.
- clear_match in M_ISSUE/M_RELEASE: ignored (no queuing).
- Latency: user_go seen at edge t gives game_start=1 after t. With a core taking 2 cycles to RESULT, round_done pulses 3 cycles after game_start rises. game_start falls the same edge round_done rises.
- Reset mid-round: immediate return to reset values, game_start=0 next edge.
- Pulses last exactly one cycle; never both high together.

Test Plan:
1. Bench core model; p1=00, p2=10, cpu_mode=0, pulse user_go -> game_start 1 for 3 cycles, round_done pulse, score_p1=1, last_winner=01, back to M_IDLE after core IDLE.
2. Two more rounds with p1=01/p2=01 then p1=01/p2=00 -> ties=1, then score_p1=2, match_over=1, match_winner=01; further user_go ignored; clear_match -> all scores 0, match_over=0.
3. p1=11, p2=00 (core returns winner 11) -> void_round pulse, scores/ties unchanged, last_winner=11.
4. Core model frozen in IDLE; user_go -> after TIMEOUT=16 cycles timeout_err=1, game_start=0, FSM M_IDLE; next round still plays normally.
5. cpu_mode=1 over 50 rounds -> game_p2_move never 11; sequence matches reference LFSR from SEED 8'hA5 with cycle-exact go timing.
6. Assert reset during M_ISSUE -> next edge game_start=0, all scores 0, busy=0; clear_match asserted during M_RELEASE -> ignored, score still increments.

Source files
------------

// File: rtl/rps_match_controller.sv
// ---------------------------------------------------------------------------
// rps_match_controller
//   Initiator side of the stone-paper-scissors core handshake. One round:
//   latch both moves, raise game_start, wait for the core status to show
//   RESULT, score the reported winner, drop game_start, wait for the core
//   to return to IDLE. Round wins accumulate into a best-of match. Player 2
//   can be driven from a free-running LFSR (CPU opponent).
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   user_go           : request a round (sampled in M_IDLE only)
//   user_p1_move      : player 1 move (00 stone, 01 paper, 10 scissors)
//   user_p2_move      : player 2 move when cpu_mode=0
//   cpu_mode          : 1 = player 2 move comes from the LFSR
//   clear_match       : zero scores/flags (M_IDLE and M_DONE only)
//   game_status       : core status {state[2:0], winner[1:0], debug[2:0]}
//   game_start        : registered start to the core
//   game_p1/p2_move   : registered moves to the core
//   score_p1/p2, ties : round tallies (ties saturate at 255)
//   last_winner       : winner code of the last completed round
//   round_done        : 1-cycle pulse, scored round
//   void_round        : 1-cycle pulse, core reported winner 11
//   match_over        : high in M_DONE
//   match_winner      : 01 p1, 10 p2, 00 none
//   timeout_err       : sticky handshake timeout
//   busy              : high in M_ISSUE or M_RELEASE
// ---------------------------------------------------------------------------
module rps_match_controller #(
  parameter int          WINS_NEEDED = 2,
  parameter int          TIMEOUT     = 16,
  parameter logic [7:0]  SEED        = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       user_go,
  input  logic [1:0] user_p1_move,
  input  logic [1:0] user_p2_move,
  input  logic       cpu_mode,
  input  logic       clear_match,
  input  logic [7:0] game_status,
  output logic       game_start,
  output logic [1:0] game_p1_move,
  output logic [1:0] game_p2_move,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [7:0] ties,
  output logic [1:0] last_winner,
  output logic       round_done,
  output logic       void_round,
  output logic       match_over,
  output logic [1:0] match_winner,
  output logic       timeout_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    M_IDLE    = 2'd0,
    M_ISSUE   = 2'd1,
    M_RELEASE = 2'd2,
    M_DONE    = 2'd3
  } state_t;

  localparam logic [2:0] CORE_IDLE   = 3'b000;
  localparam logic [2:0] CORE_RESULT = 3'b010;
  localparam logic [3:0] WINS        = 4'(WINS_NEEDED);
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);

  // core status fields
  logic [2:0] core_state;
  logic [1:0] core_winner;
  logic       unused_debug;

  assign core_state   = game_status[7:5];
  assign core_winner  = game_status[4:3];
  assign unused_debug = ^game_status[2:0];

  // state and datapath registers
  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       game_start_q, game_start_d;
  logic [1:0] p1_move_q, p1_move_d;
  logic [1:0] p2_move_q, p2_move_d;
  logic [3:0] score_p1_q, score_p1_d;
  logic [3:0] score_p2_q, score_p2_d;
  logic [7:0] ties_q, ties_d;
  logic [1:0] last_winner_q, last_winner_d;
  logic       round_done_q, round_done_d;
  logic       void_round_q, void_round_d;
  logic [1:0] match_winner_q, match_winner_d;
  logic       timeout_err_q, timeout_err_d;

  // decoded events
  logic       go_fire;
  logic       result_seen;
  logic       idle_seen;
  logic       tmo_hit;
  logic       clr_fire;
  logic [1:0] cpu_move;
  logic       lfsr_fb;

  // x^8+x^6+x^5+x^4+1, shifted in at the LSB. Free-running so the CPU move
  // depends on the exact cycle user_go is accepted.
  assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign cpu_move = (lfsr_q[1:0] == 2'b11) ? 2'b00 : lfsr_q[1:0];

  assign go_fire     = (state_q == M_IDLE) && !clear_match && user_go;
  assign result_seen = (state_q == M_ISSUE) && (core_state == CORE_RESULT);
  assign idle_seen   = (state_q == M_RELEASE) && (core_state == CORE_IDLE);
  assign tmo_hit     = (tmo_cnt_q == TMO_LAST);
  // clear is only honoured when no handshake is in flight
  assign clr_fire    = clear_match && ((state_q == M_IDLE) || (state_q == M_DONE));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= M_IDLE;
    else       state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      M_IDLE: begin
        if (go_fire) state_d = M_ISSUE;
      end
      M_ISSUE: begin
        // the awaited status wins over a coincident timeout
        if (core_state == CORE_RESULT) state_d = M_RELEASE;
        else if (tmo_hit)              state_d = M_IDLE;
      end
      M_RELEASE: begin
        if (core_state == CORE_IDLE) begin
          if ((score_p1_q == WINS) || (score_p2_q == WINS)) state_d = M_DONE;
          else                                              state_d = M_IDLE;
        end else if (tmo_hit) begin
          state_d = M_IDLE;
        end
      end
      M_DONE: begin
        if (clear_match) state_d = M_IDLE;
      end
      default: state_d = M_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    lfsr_d         = {lfsr_q[6:0], lfsr_fb};
    p1_move_d      = p1_move_q;
    p2_move_d      = p2_move_q;
    score_p1_d     = score_p1_q;
    score_p2_d     = score_p2_q;
    ties_d         = ties_q;
    last_winner_d  = last_winner_q;
    match_winner_d = match_winner_q;
    timeout_err_d  = timeout_err_q;
    round_done_d   = 1'b0;
    void_round_d   = 1'b0;

    // start is high exactly while the next state is M_ISSUE, so it drops on
    // the same edge that scores the round or aborts on timeout
    game_start_d = (state_d == M_ISSUE);

    // counter restarts on every state change, counts while a state is held
    if (((state_q == M_ISSUE) || (state_q == M_RELEASE)) && (state_d == state_q))
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    else
      tmo_cnt_d = 8'd0;

    if (go_fire) begin
      p1_move_d = user_p1_move;
      p2_move_d = cpu_mode ? cpu_move : user_p2_move;
    end

    if (result_seen) begin
      last_winner_d = core_winner;
      unique case (core_winner)
        2'b01: begin score_p1_d = score_p1_q + 4'd1; round_done_d = 1'b1; end
        2'b10: begin score_p2_d = score_p2_q + 4'd1; round_done_d = 1'b1; end
        2'b00: begin
          if (ties_q != 8'hFF) ties_d = ties_q + 8'd1;
          round_done_d = 1'b1;
        end
        default: void_round_d = 1'b1;
      endcase
    end

    if (idle_seen) begin
      if (score_p1_q == WINS)      match_winner_d = 2'b01;
      else if (score_p2_q == WINS) match_winner_d = 2'b10;
    end

    if (((state_q == M_ISSUE) && !result_seen && tmo_hit) ||
        ((state_q == M_RELEASE) && !idle_seen && tmo_hit))
      timeout_err_d = 1'b1;

    if (clr_fire) begin
      score_p1_d     = 4'd0;
      score_p2_d     = 4'd0;
      ties_d         = 8'd0;
      last_winner_d  = 2'b00;
      match_winner_d = 2'b00;
      timeout_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q         <= SEED;
      tmo_cnt_q      <= 8'd0;
      game_start_q   <= 1'b0;
      p1_move_q      <= 2'b00;
      p2_move_q      <= 2'b00;
      score_p1_q     <= 4'd0;
      score_p2_q     <= 4'd0;
      ties_q         <= 8'd0;
      last_winner_q  <= 2'b00;
      round_done_q   <= 1'b0;
      void_round_q   <= 1'b0;
      match_winner_q <= 2'b00;
      timeout_err_q  <= 1'b0;
    end else begin
      lfsr_q         <= lfsr_d;
      tmo_cnt_q      <= tmo_cnt_d;
      game_start_q   <= game_start_d;
      p1_move_q      <= p1_move_d;
      p2_move_q      <= p2_move_d;
      score_p1_q     <= score_p1_d;
      score_p2_q     <= score_p2_d;
      ties_q         <= ties_d;
      last_winner_q  <= last_winner_d;
      round_done_q   <= round_done_d;
      void_round_q   <= void_round_d;
      match_winner_q <= match_winner_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    match_over = (state_q == M_DONE);
    busy       = (state_q == M_ISSUE) || (state_q == M_RELEASE);
  end

  assign game_start   = game_start_q;
  assign game_p1_move = p1_move_q;
  assign game_p2_move = p2_move_q;
  assign score_p1     = score_p1_q;
  assign score_p2     = score_p2_q;
  assign ties         = ties_q;
  assign last_winner  = last_winner_q;
  assign round_done   = round_done_q;
  assign void_round   = void_round_q;
  assign match_winner = match_winner_q;
  assign timeout_err  = timeout_err_q;

endmodule
